// File: rtl/mem_stage_responder_pkg.sv
// Shared definitions for the memory-stage responder.
//   Signal / Register : scalar and register-index types of the pipeline
//   M_data / M_input  : request bundle driven by the X->M forwarding logic
//   mem_state_e       : responder FSM states
//   W_data            : load result returned to writeback
package mem_stage_responder_pkg;

  typedef logic       Signal;
  typedef logic [4:0] Register;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] val;
    Register     dst;
  } M_data;

  typedef struct packed {
    Signal read;
    Signal write;
    M_data data;
  } M_input;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [31:0] val;
    Register     dst;
    Signal       valid;
  } W_data;

endpackage

// File: rtl/mem_stage_responder_if.sv
// Bus between the X->M stage (master) and the memory-stage responder (slave).
//   m_in     : request bundle (read, write, addr, val, dst)
//   stall    : upstream must hold m_in and freeze X/M registers
//   w        : load result to writeback (valid, val, dst)
//   st_done  : store committed pulse
//   misalign : misaligned request dropped pulse
//   conflict : read and write asserted together pulse
interface mem_stage_responder_if;
  import mem_stage_responder_pkg::*;

  M_input m_in;
  Signal  stall;
  W_data  w;
  Signal  st_done;
  Signal  misalign;
  Signal  conflict;

  modport master (output m_in, input stall, w, st_done, misalign, conflict);
  modport slave  (input m_in, output stall, w, st_done, misalign, conflict);

endinterface

// File: rtl/mem_stage_responder_mem_sp_ram.sv
// mem_sp_ram: DEPTH x 32 synchronous RAM with one write port and one registered
// read port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   we_i/waddr_i/wdata_i: write port
//   re_i/raddr_i        : read port, data appears on rdata_o after the edge
//   rdata_o             : registered read data, cleared on reset
// INIT_Z=1 clears the whole array on reset; INIT_Z=0 leaves contents untouched.
module mem_sp_ram #(
  parameter int DEPTH  = 256,
  parameter bit INIT_Z = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  generate
    if (INIT_Z) begin : g_clear
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
          mem_q[waddr_i] <= wdata_i;
        end
      end
    end else begin : g_keep
      // No clear, but a write must never land while reset is held.
      always_ff @(posedge clk) begin
        if (we_i && rst_n) mem_q[waddr_i] <= wdata_i;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage_responder.sv
// mem_stage_responder: consumes the M_input request bundle, owns the data RAM
// and returns load results to writeback after LAT cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_stage_responder_if.slave (m_in in; stall, w, st_done,
//                misalign, conflict out)
// Optional feature macro: MEM_WRITE_POST_EN (posted stores through a
// single-entry buffer with load forwarding).
//
// state | meaning
// IDLE  | no access in flight, may accept
// WAIT  | access in flight, counting down, stall asserted
// DONE  | access completes this cycle, may accept the next one
module mem_stage_responder
  import mem_stage_responder_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int LAT    = 3,
  parameter bit INIT_Z = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_stage_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  M_input        req_q, req_d, act, launch_src;
  logic          req_present, can_accept, accept, drop, launch, go_done;
  logic          stall_q, w_valid_q, w_valid_d, st_done_q, st_done_d;
  logic          misalign_q, misalign_d, conflict_q, conflict_d;
  Register       w_dst_q, w_dst_d;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          unused_bits;

`ifdef MEM_WRITE_POST_EN
  logic          buf_valid_q, buf_load, drain_now;
  logic [AW-1:0] buf_idx_q;
  logic [31:0]   buf_val_q;
  logic [CW-1:0] buf_cnt_q;
  M_input        buf_src;
  logic          hold_q, hold_d, fwd_q, fwd_d;
  logic [31:0]   fwd_val_q, fwd_val_d;
  logic          unused_post_bits;

  assign drain_now = buf_valid_q && (buf_cnt_q == CW'(1));
`endif

  assign req_present = bus.m_in.read | bus.m_in.write;
  assign can_accept  = (state_q == IDLE) || (state_q == DONE);
  assign accept      = can_accept && req_present && (bus.m_in.data.addr[1:0] == 2'b00);
  assign drop        = can_accept && req_present && (bus.m_in.data.addr[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    act        = req_q;
    launch     = 1'b0;
    launch_src = req_q;
    go_done    = 1'b0;
    w_valid_d  = 1'b0;
    w_dst_d    = '0;
    st_done_d  = 1'b0;
    conflict_d = 1'b0;
    misalign_d = drop;
`ifdef MEM_WRITE_POST_EN
    hold_d     = hold_q;
    fwd_d      = 1'b0;
    fwd_val_d  = '0;
    buf_load   = 1'b0;
    buf_src    = req_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          req_d = bus.m_in;
`ifdef MEM_WRITE_POST_EN
          if (buf_valid_q && !bus.m_in.write &&
              (bus.m_in.data.addr[AW+1:2] == buf_idx_q)) begin
            // Load hits the undrained store: answer from the buffer next cycle.
            fwd_d     = 1'b1;
            fwd_val_d = buf_val_q;
            w_valid_d = 1'b1;
            w_dst_d   = bus.m_in.data.dst;
            state_d   = DONE;
          end else if (buf_valid_q && !drain_now) begin
            hold_d  = 1'b1;
            state_d = WAIT;
          end else if (bus.m_in.write) begin
            buf_load   = 1'b1;
            buf_src    = bus.m_in;
            st_done_d  = 1'b1;
            conflict_d = bus.m_in.read;
            state_d    = DONE;
          end else begin
            launch     = 1'b1;
            launch_src = bus.m_in;
          end
`else
          launch     = 1'b1;
          launch_src = bus.m_in;
`endif
        end
      end
      WAIT: begin
`ifdef MEM_WRITE_POST_EN
        if (hold_q) begin
          if (drain_now) begin
            hold_d = 1'b0;
            if (req_q.write) begin
              buf_load   = 1'b1;
              buf_src    = req_q;
              st_done_d  = 1'b1;
              conflict_d = req_q.read;
              state_d    = DONE;
            end else begin
              launch = 1'b1;
            end
          end
        end else
`endif
        if (cnt_q == CW'(1)) begin
          go_done = 1'b1;
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // LAT==1 completes on the accept edge itself, so the RAM sees m_in directly.
    if (launch) begin
      if (LAT == 1) begin
        go_done = 1'b1;
        act     = launch_src;
        state_d = DONE;
      end else begin
        state_d = WAIT;
        cnt_d   = CW'(LAT - 1);
      end
    end

    if (go_done) begin
      if (act.write) begin
        st_done_d  = 1'b1;
        conflict_d = act.read;
      end else begin
        w_valid_d = 1'b1;
        w_dst_d   = act.data.dst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      stall_q    <= 1'b0;
      w_valid_q  <= 1'b0;
      w_dst_q    <= '0;
      st_done_q  <= 1'b0;
      misalign_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      stall_q    <= (state_d == WAIT);
      w_valid_q  <= w_valid_d;
      w_dst_q    <= w_dst_d;
      st_done_q  <= st_done_d;
      misalign_q <= misalign_d;
      conflict_q <= conflict_d;
    end
  end

`ifdef MEM_WRITE_POST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_val_q   <= '0;
      buf_cnt_q   <= '0;
      hold_q      <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_val_q   <= '0;
    end else begin
      hold_q    <= hold_d;
      fwd_q     <= fwd_d;
      fwd_val_q <= fwd_val_d;
      if (buf_load) begin
        buf_valid_q <= 1'b1;
        buf_idx_q   <= buf_src.data.addr[AW+1:2];
        buf_val_q   <= buf_src.data.val;
        buf_cnt_q   <= CW'(LAT);
      end else if (buf_valid_q) begin
        buf_valid_q <= !drain_now;
        buf_cnt_q   <= buf_cnt_q - CW'(1);
      end
    end
  end

  assign ram_we    = drain_now;
  assign ram_waddr = buf_idx_q;
  assign ram_wdata = buf_val_q;
  assign bus.w.val = w_valid_q ? (fwd_q ? fwd_val_q : ram_rdata) : '0;
  assign unused_post_bits = ^{buf_src.data.addr[31:AW+2], buf_src.data.addr[1:0],
                              buf_src.data.dst, buf_src.write, buf_src.read, act.data.val};
`else
  assign ram_we    = go_done & act.write;
  assign ram_waddr = act.data.addr[AW+1:2];
  assign ram_wdata = act.data.val;
  assign bus.w.val = w_valid_q ? ram_rdata : '0;
`endif

  assign ram_re    = go_done & ~act.write;
  assign ram_raddr = act.data.addr[AW+1:2];

  // Upper address bits wrap away; the low two bits only matter for alignment.
  assign unused_bits = ^{act.data.addr[31:AW+2], act.data.addr[1:0]};

  mem_sp_ram #(
    .DEPTH (DEPTH),
    .INIT_Z(INIT_Z)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  assign bus.stall    = stall_q;
  assign bus.w.valid  = w_valid_q;
  assign bus.w.dst    = w_dst_q;
  assign bus.st_done  = st_done_q;
  assign bus.misalign = misalign_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
module tb_mem_stage_responder;
  import mem_stage_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        c_stall [1:5];
  logic        c_wv    [1:5];
  logic [31:0] c_wval  [1:5];
  logic [4:0]  c_wdst  [1:5];
  logic        c_st    [1:5];
  logic        c_mis   [1:5];
  logic        c_conf  [1:5];

  always #5 clk = ~clk;

  mem_stage_responder_if if3 ();
  mem_stage_responder_if if1 ();

  mem_stage_responder #(.DEPTH(256), .LAT(3), .INIT_Z(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3)
  );
  mem_stage_responder #(.DEPTH(256), .LAT(1), .INIT_Z(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req3(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] val, input logic [4:0] dst);
    if3.m_in.read = rd; if3.m_in.write = wr;
    if3.m_in.data.addr = addr; if3.m_in.data.val = val; if3.m_in.data.dst = dst;
  endtask

  task automatic req1(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] val, input logic [4:0] dst);
    if1.m_in.read = rd; if1.m_in.write = wr;
    if1.m_in.data.addr = addr; if1.m_in.data.val = val; if1.m_in.data.dst = dst;
  endtask

  // Request already driven; cycle k of the capture is cycle c+k.
  task automatic run3(input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 1) req3(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      c_stall[k] = if3.stall;   c_wv[k]  = if3.w.valid; c_wval[k] = if3.w.val;
      c_wdst[k]  = if3.w.dst;   c_st[k]  = if3.st_done; c_mis[k]  = if3.misalign;
      c_conf[k]  = if3.conflict;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    req3(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    req1(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b0;
    step(); step();
    chk("rst3_outs", {27'd0, if3.stall, if3.w.valid, if3.st_done, if3.misalign, if3.conflict}, 32'h0);
    chk("rst3_wval", if3.w.val, 32'h0);
    chk("rst1_outs", {27'd0, if1.stall, if1.w.valid, if1.st_done, if1.misalign, if1.conflict}, 32'h0);
    rst_n = 1'b1;
    step();

    // 1: store, LAT=3
    req3(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
    run3(4);
    chk("st_stall_c1", c_stall[1], 1); chk("st_stall_c2", c_stall[2], 1);
    chk("st_stall_c3", c_stall[3], 0); chk("st_done_c2", c_st[2], 0);
    chk("st_done_c3", c_st[3], 1);     chk("st_done_c4", c_st[4], 0);
    chk("st_wvalid_c3", c_wv[3], 0);

    // 2: load back
    req3(1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
    run3(4);
    chk("ld_stall_c1", c_stall[1], 1); chk("ld_wv_c2", c_wv[2], 0);
    chk("ld_wv_c3", c_wv[3], 1);       chk("ld_wv_c4", c_wv[4], 0);
    chk("ld_wval_c3", c_wval[3], 32'hDEADBEEF);
    chk("ld_wdst_c3", c_wdst[3], 5);

    // 4: misaligned load, then wrapped address
    req3(1'b1, 1'b0, 32'h13, 32'h0, 5'd3);
    run3(3);
    chk("mis_c1", c_mis[1], 1);        chk("mis_c2", c_mis[2], 0);
    chk("mis_stall_c1", c_stall[1], 0);
    chk("mis_wv", {c_wv[1], c_wv[2], c_wv[3]}, 0);
    req3(1'b1, 1'b0, 32'd1024 + 32'h10, 32'h0, 5'd9);
    run3(4);
    chk("wrap_wv_c3", c_wv[3], 1);
    chk("wrap_wval_c3", c_wval[3], 32'hDEADBEEF);

    // 5: read and write together
    req3(1'b1, 1'b1, 32'h20, 32'd7, 5'd2);
    run3(4);
    chk("conf_c2", c_conf[2], 0); chk("conf_c3", c_conf[3], 1); chk("conf_c4", c_conf[4], 0);
    chk("conf_st_c3", c_st[3], 1); chk("conf_wv_c3", c_wv[3], 0);
    req3(1'b1, 1'b0, 32'h20, 32'h0, 5'd1);
    run3(4);
    chk("conf_rd_wval", c_wval[3], 32'd7);

    // 3: LAT=1 back-to-back stores then loads
    for (int k = 0; k < 4; k++) begin
      req1(1'b0, 1'b1, 32'(k * 4), vals[k], 5'd0);
      step();
      chk($sformatf("b2b_st_stall%0d", k), if1.stall, 0);
      chk($sformatf("b2b_st_done%0d", k), if1.st_done, 1);
    end
    req1(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("b2b_st_done_end", if1.st_done, 0);
    for (int k = 0; k < 4; k++) begin
      req1(1'b1, 1'b0, 32'(k * 4), 32'h0, 5'(k + 1));
      step();
      chk($sformatf("b2b_ld_stall%0d", k), if1.stall, 0);
      chk($sformatf("b2b_ld_wv%0d", k), if1.w.valid, 1);
      chk($sformatf("b2b_ld_val%0d", k), if1.w.val, vals[k]);
      chk($sformatf("b2b_ld_dst%0d", k), if1.w.dst, 32'(k + 1));
    end
    req1(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("b2b_ld_wv_end", if1.w.valid, 0);

    // 6: reset during a store in WAIT
    req3(1'b0, 1'b1, 32'h20, 32'h55, 5'd0);
    step();
    chk("rstmid_stall_before", if3.stall, 1);
    rst_n = 1'b0;
    req3(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("rstmid_outs", {27'd0, if3.stall, if3.w.valid, if3.st_done, if3.misalign, if3.conflict}, 32'h0);
    step(); step(); step();
    rst_n = 1'b1;
    step();
    req3(1'b1, 1'b0, 32'h20, 32'h0, 5'd4);
    run3(4);
    chk("rstmid_wv_c3", c_wv[3], 1);
    chk("rstmid_ram_kept", c_wval[3], 32'd7);
    chk("rstmid_no_st", c_st[3], 0);

    // INIT_Z=1 instance was cleared by the same reset
    req1(1'b1, 1'b0, 32'h4, 32'h0, 5'd6);
    step();
    req1(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("initz_wv", if1.w.valid, 1);
    chk("initz_val", if1.w.val, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
